// File: rtl/relm_i2c_pkg.sv
// Shared opcodes, command-word field positions, FSM state type and the
// per-bit SDA drive helper for the ReLM byte-level I2C master.
package relm_i2c_pkg;

  localparam logic [1:0] I2C_START = 2'd0;
  localparam logic [1:0] I2C_STOP  = 2'd1;
  localparam logic [1:0] I2C_WRITE = 2'd2;
  localparam logic [1:0] I2C_READ  = 2'd3;

  localparam int I2C_NACK_BIT = 10;
  localparam int I2C_OP_LSB   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BIT   = 2'd2,
    STOP  = 2'd3
  } i2c_state_e;

  // SDA pull-down for bit b of a byte transfer: bits 8..1 carry data, bit 0 is the ACK slot.
  function automatic logic bit_drive(input logic [1:0] op, input logic [7:0] data,
                                     input logic [3:0] b, input logic nack);
    logic       d;
    logic [2:0] idx;
    d   = 1'b0;
    idx = 3'(b - 4'd1);
    if (op == I2C_WRITE) begin
      if (b != 4'd0) d = ~data[idx];
      else           d = 1'b0;
    end else if (op == I2C_READ) begin
      if (b == 4'd0) d = ~nack;
      else           d = 1'b0;
    end else begin
      d = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/relm_i2c_sync.sv
// Two-flop synchroniser for an asynchronous I2C pin; resets to the released
// (high) level so a bus held in reset reads as idle.
module relm_i2c_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/relm_i2c_master.sv
// Byte-level I2C master driven by ReLM push/pop words (START/STOP/WRITE/READ).
// Define RELM_I2C_STRETCH_EN to honour slave clock stretching via scl_in.
module relm_i2c_master
  import relm_i2c_pkg::*;
#(
  parameter int WD  = 32,
  parameter int DIV = 125
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WD:0]   cmd_d,
  output logic          cmd_retry,
  output logic [WD:0]   rsp_q,
  input  logic [WD:0]   rsp_d,
  output logic          scl_out,
  output logic          sda_oe,
  input  logic          sda_in,
  input  logic          scl_in
);

  localparam logic [9:0] Q_LAST = 10'(DIV - 1);

  i2c_state_e  state_q;
  logic        busy_q;
  logic [9:0]  q_q;
  logic [1:0]  ph_q;
  logic [3:0]  b_q;
  logic [1:0]  op_q;
  logic [7:0]  data_q;
  logic        nack_q;
  logic [7:0]  shift_q;
  logic        ack_q;
  logic        rsp_ack_q;
  logic [7:0]  rsp_data_q;
  logic        scl_q;
  logic        sda_oe_q;

  logic        sda_s;
  logic        hold_s;
  logic        tick_s;
  logic        last_s;
  logic        drive_s;
  logic        accept_s;
  logic [1:0]  op_s;
  logic [9:0]  q_d;
  logic        unused_s;

  relm_i2c_sync u_sda_sync (
    .clk (clk),
    .rst (rst),
    .d_i (sda_in),
    .q_o (sda_s)
  );

`ifdef RELM_I2C_STRETCH_EN
  logic scl_s;

  relm_i2c_sync u_scl_sync (
    .clk (clk),
    .rst (rst),
    .d_i (scl_in),
    .q_o (scl_s)
  );

  // A slave holding SCL low parks the high phase at its first quarter.
  assign hold_s = (state_q == BIT) && (ph_q == 2'd2) && (q_q == 10'd0) && !scl_s;
`else
  assign hold_s = 1'b0;
`endif

  assign op_s     = cmd_d[I2C_OP_LSB +: 2];
  assign accept_s = cmd_d[WD] && !busy_q;
  assign tick_s   = (q_q == Q_LAST) && !hold_s;
  assign q_d      = hold_s ? q_q : (tick_s ? 10'd0 : q_q + 10'd1);
  assign last_s   = tick_s && (ph_q == 2'd3) && ((state_q != BIT) || (b_q == 4'd0));
  assign drive_s  = bit_drive(op_q, data_q, b_q, nack_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      q_q        <= 10'd0;
      ph_q       <= 2'd0;
      b_q        <= 4'd0;
      op_q       <= 2'd0;
      data_q     <= 8'd0;
      nack_q     <= 1'b0;
      shift_q    <= 8'd0;
      ack_q      <= 1'b0;
      rsp_ack_q  <= 1'b0;
      rsp_data_q <= 8'd0;
      scl_q      <= 1'b1;
      sda_oe_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            busy_q <= 1'b1;
            op_q   <= op_s;
            data_q <= cmd_d[7:0];
            nack_q <= cmd_d[I2C_NACK_BIT];
            q_q    <= 10'd0;
            ph_q   <= 2'd0;
            b_q    <= 4'd8;
            case (op_s)
              I2C_START: state_q <= START;
              I2C_STOP:  state_q <= STOP;
              default:   state_q <= BIT;
            endcase
          end
        end
        START: begin
          case (ph_q)
            2'd0:    begin scl_q <= 1'b1; sda_oe_q <= 1'b0; end
            2'd1:    begin scl_q <= 1'b1; sda_oe_q <= 1'b1; end
            2'd2:    begin scl_q <= 1'b0; sda_oe_q <= 1'b1; end
            default: ;
          endcase
        end
        STOP: begin
          case (ph_q)
            2'd0:    begin scl_q <= 1'b0; sda_oe_q <= 1'b1; end
            2'd1:    begin scl_q <= 1'b1; sda_oe_q <= 1'b1; end
            2'd2:    begin scl_q <= 1'b1; sda_oe_q <= 1'b0; end
            default: ;
          endcase
        end
        BIT: begin
          scl_q    <= (ph_q == 2'd1) || (ph_q == 2'd2);
          sda_oe_q <= drive_s;
          if (tick_s && (ph_q == 2'd2)) begin
            if (b_q == 4'd0) ack_q   <= sda_s;
            else             shift_q <= {shift_q[6:0], sda_s};
          end
          if (tick_s && (ph_q == 2'd3) && (b_q != 4'd0)) begin
            b_q <= b_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (state_q != IDLE) begin
        q_q <= q_d;
        if (tick_s) ph_q <= ph_q + 2'd1;
      end

      // Response fields change only when a byte transfer finishes.
      if (last_s) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        if (state_q == BIT) begin
          rsp_ack_q  <= ack_q;
          rsp_data_q <= shift_q;
        end
      end
    end
  end

  assign cmd_retry = busy_q;
  assign rsp_q     = {busy_q, {(WD - 9){1'b0}}, rsp_ack_q, rsp_data_q};
  assign scl_out   = scl_q;
  assign sda_oe    = sda_oe_q;

  assign unused_s  = ^{rsp_d, cmd_d[WD-1:11], scl_in};

endmodule

// File: doc/relm_i2c_master.md
# relm_i2c_master

Byte-level I2C master that sits between the ReLM core's push/pop ports and the I2C pins on the DE0-Nano (accelerometer bus). It replaces per-bit software toggling of SCL/SDA with START/STOP/WRITE/READ commands. Commands arrive on a push port using the `[WD]`-valid word format. Status and read data are returned on a pop port, with bit `[WD]` acting as retry.

## Interface

Parameters:

- `WD`, 32 — data word width; ports carry `WD+1` bits, and bit `WD` is the valid/retry flag.
- `DIV`, 125 — clk cycles per SCL quarter-period. At 50 MHz this gives 100 kHz. Legal range is 1..1023.

Ports:

- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous, active-high reset.
- `cmd_d` in WD+1 — push word.
  - `[WD]` valid.
  - `[9:8]` opcode: 0 START, 1 STOP, 2 WRITE, 3 READ.
  - `[7:0]` write byte.
  - `[10]` READ nack: 1 = master sends NACK.
- `cmd_retry` out 1 — high while the engine is busy; the push is not accepted.
- `rsp_q` out WD+1 — pop word.
  - `[WD]` busy (retry).
  - `[8]` last ACK bit sampled (0 = ACK).
  - `[7:0]` last read byte.
  - All other bits 0.
- `rsp_d` in WD+1 — pop strobe; `[WD]` marks a read. The strobe has no side effect and exists only for port symmetry.
- `scl_out` out 1 — SCL drive; 1 = released.
- `sda_oe` out 1 — 1 = drive SDA low; 0 = release SDA.
- `sda_in` in 1 — SDA pin, unsynchronised.
- `scl_in` in 1 — SCL pin, unsynchronised. Used only with `RELM_I2C_STRETCH_EN`.

## Operation

- Accept rule: a command is accepted on a `clk` edge where `cmd_d[WD]=1` and `busy=0`. `busy` goes to 1 on the same edge.
- `cmd_retry` and `rsp_q[WD]` are both equal to `busy`, a register.
- Inputs `sda_in` and `scl_in` pass through 2-flop synchronisers before any use.
- FSM states: `IDLE`, `START`, `BIT`, `STOP`.
- Quarter counter `q` runs 0..DIV-1. On wrap it advances the phase `ph` (0..3).
- START:
  - ph0: SDA released, SCL released.
  - ph1: SDA low.
  - ph2: SCL low.
  - ph3: hold.
  - Then return to IDLE.
- STOP:
  - ph0: SDA low, SCL low.
  - ph1: SCL released.
  - ph2: SDA released.
  - ph3: hold.
  - Then return to IDLE.
- BIT: 9 bits, indexed `b` = 8..0. Per bit:
  - ph0: SCL low; set SDA.
  - ph1: SCL released.
  - ph2: sample SDA at the end of ph2.
  - ph3: SCL low.
- WRITE: bits 8..1 drive `data[7:0]` MSB first, with `sda_oe = ~bit`. Bit 0 releases SDA and samples ACK into `rsp_q[8]`.
- READ: bits 8..1 release SDA and shift samples into `rsp_q[7:0]` MSB first. Bit 0 drives ACK (`sda_oe=1`) when `nack=0`, and releases SDA when `nack=1`.
- `rsp_q[8:0]` updates only when WRITE or READ completes. It holds through START and STOP.
- On completion, `busy` clears on the last cycle of ph3.
- Commands issued out of protocol order (for example WRITE without START) execute literally; no checking is done.
- Reset mid-operation:
  - `scl_out=1`, `sda_oe=0` immediately.
  - FSM to IDLE, `busy=0`, `rsp_q[8:0]=0`.
  - The bus is left released; software must issue STOP/START again.

## Timing

- Reset values: `scl_out=1`, `sda_oe=0`, `cmd_retry=0`, `rsp_q=0`.
- `busy` duration from the accept edge:
  - START and STOP: 4·DIV cycles.
  - WRITE and READ: 36·DIV cycles.
- The next command can be accepted on the edge after `busy` falls. There are no idle gap cycles.
- `scl_out` and `sda_oe` are registered. Pin changes lag FSM state by 1 cycle.
- The SDA sample reflects the pin 2 cycles earlier because of the synchroniser.

## Configuration

- `RELM_I2C_STRETCH_EN` defined:
  - In ph2 of BIT, `q` is frozen at 0 while the synchronised `scl_in=0`. This honours slave clock stretching.
  - Busy duration extends by the stretch length.
- Undefined:
  - `scl_in` is ignored and timing is exactly as stated above.
  - No synchroniser is built for `scl_in`.

## Structure

- Package `relm_i2c_pkg` holds:
  - opcode localparams `I2C_START`, `I2C_STOP`, `I2C_WRITE`, `I2C_READ`;
  - the state enum;
  - bit-field positions (`I2C_NACK_BIT=10`, `I2C_OP_LSB=8`).
- One sub-module: `relm_i2c_sync`, a 2-flop synchroniser with async reset to 1. It is instantiated for `sda_in`, and for `scl_in` only under the macro.

## Test plan

- Reset then idle, DIV=4 → `scl_out=1`, `sda_oe=0`, `rsp_q=0`, `cmd_retry=0`.
- START then WRITE `0xA6` with the slave pulling ACK low on the 9th bit:
  - SDA pattern on SCL rising edges is 1,0,1,0,0,1,1,0, then released.
  - `rsp_q[8]=0` afterwards.
  - Busy lasts 16 cycles for START and 144 cycles for WRITE.
- WRITE with no slave (SDA floats high) → `rsp_q[8]=1`.
- READ with nack=1 while the slave drives `0x5A` → `rsp_q[7:0]=0x5A`; SDA released on bit 0.
- READ with nack=0 → `sda_oe=1` during bit 0.
- Push attempted while busy → `cmd_retry=1`; the command is ignored. The same word re-pushed after busy falls is executed once.
- `rst` asserted mid-WRITE → outputs return to reset values asynchronously; a subsequent START runs normally.
- Stretching, with the macro defined: hold `scl_in=0` for 50 cycles in bit 5 → busy extends by 50 cycles and the data is still correct.
